// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one combinational ALU, with a
// single registered response slot that supports one op per cycle.

module alu (
    input  logic [4:0]  opcode,
    input  logic [4:0]  shamt,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        ne,
    output logic        lt,
    output logic        ovf,
    output logic        err
);
    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result = 32'd0;
        ne     = 1'b0;
        lt     = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (opcode)
            5'b00000: begin
                result = sum;
                ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            5'b00001: begin
                result = diff;
                ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
                ne     = (a != b);
                // Sign of the difference is inverted when the subtract overflows
                lt     = diff[31] ^ ovf;
            end
            5'b00010: result = a & b;
            5'b00011: result = a | b;
            5'b00100: result = a << shamt;
            5'b00101: result = $unsigned($signed(a) >>> shamt);
            default:  err = 1'b1;
        endcase
    end
endmodule

module alu_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_opcode,
    input  logic [4:0]  req0_shamt,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_opcode,
    input  logic [4:0]  req1_shamt,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_ne,
    output logic        rsp_lt,
    output logic        rsp_ovf,
    output logic        rsp_err
);
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_ne_q, rsp_ne_d;
    logic        rsp_lt_q, rsp_lt_d;
    logic        rsp_ovf_q, rsp_ovf_d;
    logic        rsp_err_q, rsp_err_d;
    logic        ptr_q, ptr_d;

    logic        slot_free;
    logic        grant0, grant1;
    logic        xfer;
    logic [4:0]  alu_opcode, alu_shamt;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_ne, alu_lt, alu_ovf, alu_err;

    // ptr_q holds the last granted requester; the other one wins a tie
    assign slot_free  = !rsp_valid_q || rsp_ready;
    assign grant0     = req0_valid && (!req1_valid || ptr_q);
    assign grant1     = req1_valid && (!req0_valid || !ptr_q);
    assign req0_ready = grant0 && slot_free && reset_n;
    assign req1_ready = grant1 && slot_free && reset_n;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign alu_opcode = grant1 ? req1_opcode : req0_opcode;
    assign alu_shamt  = grant1 ? req1_shamt  : req0_shamt;
    assign alu_a      = grant1 ? req1_a      : req0_a;
    assign alu_b      = grant1 ? req1_b      : req0_b;

    alu u_alu (
        .opcode (alu_opcode),
        .shamt  (alu_shamt),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .ne     (alu_ne),
        .lt     (alu_lt),
        .ovf    (alu_ovf),
        .err    (alu_err)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_ne_d     = rsp_ne_q;
        rsp_lt_d     = rsp_lt_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        ptr_d        = ptr_q;
        if (xfer) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant1;
            rsp_result_d = alu_result;
            rsp_ne_d     = alu_ne;
            rsp_lt_d     = alu_lt;
            rsp_ovf_d    = alu_ovf;
            rsp_err_d    = alu_err;
            ptr_d        = grant1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_ne_q     <= 1'b0;
            rsp_lt_q     <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            ptr_q        <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_ne_q     <= rsp_ne_d;
            rsp_lt_q     <= rsp_lt_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
            ptr_q        <= ptr_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_ne     = rsp_ne_q;
    assign rsp_lt     = rsp_lt_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table plus hand-written
// backpressure and mid-operation reset sequences.

module tb_alu_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_opcode, req0_shamt, req1_opcode, req1_shamt;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_ne, rsp_lt, rsp_ovf, rsp_err;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    alu_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_shamt(req0_shamt), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_shamt(req1_shamt), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_ne(rsp_ne), .rsp_lt(rsp_lt),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
    );

    typedef struct {
        logic        v0; logic [4:0] op0; logic [4:0] sh0; logic [31:0] a0; logic [31:0] b0;
        logic        v1; logic [4:0] op1; logic [4:0] sh1; logic [31:0] a1; logic [31:0] b1;
        logic        rr;
        logic        x_r0; logic x_r1;
        logic        x_v; logic x_id; logic [31:0] x_res;
        logic        x_ne; logic x_lt; logic x_ovf; logic x_err;
    } vec_t;

    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, AND_ = 5'b00010,
                           OR_ = 5'b00011, SLL = 5'b00100, SRA = 5'b00101, RSV = 5'b00111;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        req0_valid = t.v0; req0_opcode = t.op0; req0_shamt = t.sh0; req0_a = t.a0; req0_b = t.b0;
        req1_valid = t.v1; req1_opcode = t.op1; req1_shamt = t.sh1; req1_a = t.a1; req1_b = t.b1;
        rsp_ready  = t.rr;
    endtask

    task automatic check_rsp(input string nm, input vec_t t);
        chk({nm, ".flags"}, {26'd0, rsp_valid, rsp_id, rsp_ne, rsp_lt, rsp_ovf, rsp_err},
            {26'd0, t.x_v, t.x_id, t.x_ne, t.x_lt, t.x_ovf, t.x_err});
        chk({nm, ".result"}, rsp_result, t.x_res);
    endtask

    // Drive at the falling edge, check readys just after, then check the
    // registered response just after the following rising edge.
    task automatic apply(input vec_t t, input string nm);
        @(negedge clock);
        drive(t);
        #1;
        chk({nm, ".ready"}, {30'd0, req1_ready, req0_ready}, {30'd0, t.x_r1, t.x_r0});
        @(posedge clock);
        #1;
        check_rsp(nm, t);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //           v0 op0  sh0 a0            b0            v1 op1  sh1 a1            b1            rr r0 r1 v id res           ne lt ov er
        tbl[0]  = '{1, ADD, 0, 32'h00000001, 32'h00000001, 0, ADD, 0, 32'h0,        32'h0,        1, 1, 0, 1, 0, 32'h00000002, 0, 0, 0, 0};
        tbl[1]  = '{0, ADD, 0, 32'h0,        32'h0,        1, SUB, 0, 32'h80000001, 32'h7FFFFFFF, 1, 0, 1, 1, 1, 32'h00000002, 1, 1, 1, 0};
        tbl[2]  = '{1, OR_, 0, 32'hFFFFFFFF, 32'h00000000, 1, AND_,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0};
        tbl[3]  = '{1, OR_, 0, 32'hFFFFFFFF, 32'h00000000, 1, AND_,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0};
        tbl[4]  = '{1, OR_, 0, 32'hFFFFFFFF, 32'h00000000, 1, AND_,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0};
        tbl[5]  = '{1, OR_, 0, 32'hFFFFFFFF, 32'h00000000, 1, AND_,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0};
        tbl[6]  = '{1, ADD, 0, 32'h40000000, 32'h40000000, 0, ADD, 0, 32'h0,        32'h0,        1, 1, 0, 1, 0, 32'h80000000, 0, 0, 1, 0};
        tbl[7]  = '{0, ADD, 0, 32'h0,        32'h0,        1, SLL, 3, 32'h00000001, 32'h12345678, 1, 0, 1, 1, 1, 32'h00000008, 0, 0, 0, 0};
        tbl[8]  = '{1, SRA, 4, 32'h80000000, 32'h0,        0, ADD, 0, 32'h0,        32'h0,        1, 1, 0, 1, 0, 32'hF8000000, 0, 0, 0, 0};
        tbl[9]  = '{0, ADD, 0, 32'h0,        32'h0,        1, RSV, 0, 32'h00000005, 32'h00000003, 1, 0, 1, 1, 1, 32'h00000000, 0, 0, 0, 1};
        tbl[10] = '{1, SUB, 0, 32'h00000000, 32'h00000000, 0, ADD, 0, 32'h0,        32'h0,        1, 1, 0, 1, 0, 32'h00000000, 0, 0, 0, 0};
        tbl[11] = '{0, ADD, 0, 32'h0,        32'h0,        1, SUB, 0, 32'h00000005, 32'h00000007, 1, 0, 1, 1, 1, 32'hFFFFFFFE, 1, 1, 0, 0};

        // Reset with both requesters valid: readys must stay low
        reset_n = 1'b0;
        drive(tbl[2]);
        @(negedge clock);
        #1;
        chk("reset.ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("reset.rsp", {25'd0, rsp_valid, rsp_id, rsp_ne, rsp_lt, rsp_ovf, rsp_err, 1'b0}, 32'd0);
        chk("reset.result", rsp_result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(tbl[0]);
        #1;
        chk("post_reset.ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clock);
        #1;
        check_rsp("first_xfer", tbl[0]);

        for (int i = 1; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: slot full, both requesters waiting, response frozen
        for (int i = 0; i < 3; i++)
            apply(vec_t'{1, AND_, 0, 32'hF0F0F0F0, 32'hFF00FF00, 1, OR_, 0, 32'h0F0F0000, 32'h000000F0,
                         0, 0, 0, 1, 1, 32'hFFFFFFFE, 1, 1, 0, 0}, $sformatf("stall%0d", i));
        // Pointer did not move during the stall, so req0 wins as soon as the slot drains
        apply(vec_t'{1, AND_, 0, 32'hF0F0F0F0, 32'hFF00FF00, 1, OR_, 0, 32'h0F0F0000, 32'h000000F0,
                     1, 1, 0, 1, 0, 32'hF000F000, 0, 0, 0, 0}, "release0");
        apply(vec_t'{1, AND_, 0, 32'hF0F0F0F0, 32'hFF00FF00, 1, OR_, 0, 32'h0F0F0000, 32'h000000F0,
                     1, 0, 1, 1, 1, 32'h0F0F00F0, 0, 0, 0, 0}, "release1");
        // Drain with no requester, then idle with no consumer
        apply(vec_t'{0, ADD, 0, 32'h0, 32'h0, 0, ADD, 0, 32'h0, 32'h0,
                     1, 0, 0, 0, 1, 32'h0F0F00F0, 0, 0, 0, 0}, "drain");
        apply(vec_t'{0, ADD, 0, 32'h0, 32'h0, 0, ADD, 0, 32'h0, 32'h0,
                     0, 0, 0, 0, 1, 32'h0F0F00F0, 0, 0, 0, 0}, "idle");

        // Mid-operation reset: req0 granted last, slot held
        apply(vec_t'{1, ADD, 0, 32'h00000003, 32'h00000004, 0, ADD, 0, 32'h0, 32'h0,
                     0, 1, 0, 1, 0, 32'h00000007, 0, 0, 0, 0}, "pre_reset");
        @(negedge clock);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_opcode = SUB; req1_a = 32'd9; req1_b = 32'd1;
        #1;
        chk("held.ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("held.valid", {31'd0, rsp_valid}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset.valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_reset.result", rsp_result, 32'd0);
        chk("async_reset.ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("tie_after_reset.ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clock);
        #1;
        chk("tie_after_reset.id", {30'd0, rsp_valid, rsp_id}, 32'd2);
        chk("tie_after_reset.result", rsp_result, 32'h00000007);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
